// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing the data-memory port between the CPU (C) and the loader (L).
// Each access runs IDLE (capture) -> BUSY (memory access) -> DONE (ack), so one access per 3 cycles.
module mem_arbiter #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         c_req,
  input  logic [1:0]   c_memwrite,
  input  logic         c_dword,
  input  logic [N-1:0] c_adr,
  input  logic [N-1:0] c_wdata,
  output logic         c_ack,
  output logic [N-1:0] c_rdata,
  output logic         c_err,
  output logic         c_stall,
  input  logic         l_req,
  input  logic [1:0]   l_memwrite,
  input  logic         l_dword,
  input  logic [N-1:0] l_adr,
  input  logic [N-1:0] l_wdata,
  output logic         l_ack,
  output logic [N-1:0] l_rdata,
  output logic         l_err,
  input  logic         l_lock,
  output logic [1:0]   m_memwrite,
  output logic         m_dword,
  output logic [N-1:0] m_dataadr,
  output logic [N-1:0] m_writedata,
  input  logic [N-1:0] m_readdata,
  output logic         owner
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, err_q, err_d;
  logic [1:0] m_memwrite_q, m_memwrite_d;
  logic m_dword_q, m_dword_d;
  logic [N-1:0] m_dataadr_q, m_dataadr_d, m_writedata_q, m_writedata_d;
  logic c_ack_q, c_ack_d, l_ack_q, l_ack_d, c_err_q, c_err_d, l_err_q, l_err_d;
  logic [N-1:0] c_rdata_q, c_rdata_d, l_rdata_q, l_rdata_d;
  logic sel_l, sel_dw, is_dw, is_w, bad, rd_ok;
  logic [1:0] sel_mw;
  logic [N-1:0] sel_adr;
  always_comb begin
    // on a tie L wins unless it was the last owner, or it is locked in
    sel_l = l_req & (~c_req | ~owner_q | l_lock);
    sel_mw = sel_l ? l_memwrite : c_memwrite;
    sel_dw = sel_l ? l_dword : c_dword;
    sel_adr = sel_l ? l_adr : c_adr;
    is_dw = (sel_mw == 2'd3) | (sel_mw == 2'd0 & sel_dw);
    is_w = (sel_mw == 2'd1) | (sel_mw == 2'd0 & ~sel_dw);
    bad = is_dw ? |sel_adr[2:0] : is_w & |sel_adr[1:0];
    rd_ok = (m_memwrite_q == 2'd0) & ~err_q;
    state_d = state_q;
    owner_d = owner_q;
    err_d = err_q;
    m_memwrite_d = m_memwrite_q;
    m_dword_d = m_dword_q;
    m_dataadr_d = m_dataadr_q;
    m_writedata_d = m_writedata_q;
    c_ack_d = 1'b0;
    l_ack_d = 1'b0;
    c_err_d = 1'b0;
    l_err_d = 1'b0;
    c_rdata_d = c_rdata_q;
    l_rdata_d = l_rdata_q;
    unique case (state_q)
      IDLE: begin
        m_memwrite_d = 2'd0;
        if (c_req | l_req) begin
          state_d = BUSY;
          owner_d = sel_l;
          err_d = bad;
          m_memwrite_d = bad ? 2'd0 : sel_mw;
          m_dword_d = sel_dw;
          m_dataadr_d = sel_adr;
          m_writedata_d = sel_l ? l_wdata : c_wdata;
        end
      end
      BUSY: begin
        state_d = DONE;
        m_memwrite_d = 2'd0;
        c_ack_d = ~owner_q;
        l_ack_d = owner_q;
        c_err_d = ~owner_q & err_q;
        l_err_d = owner_q & err_q;
        c_rdata_d = (~owner_q & rd_ok) ? m_readdata : c_rdata_q;
        l_rdata_d = (owner_q & rd_ok) ? m_readdata : l_rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
      err_q <= 1'b0;
      m_memwrite_q <= 2'd0;
      m_dword_q <= 1'b0;
      m_dataadr_q <= '0;
      m_writedata_q <= '0;
      c_ack_q <= 1'b0;
      l_ack_q <= 1'b0;
      c_err_q <= 1'b0;
      l_err_q <= 1'b0;
      c_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      err_q <= err_d;
      m_memwrite_q <= m_memwrite_d;
      m_dword_q <= m_dword_d;
      m_dataadr_q <= m_dataadr_d;
      m_writedata_q <= m_writedata_d;
      c_ack_q <= c_ack_d;
      l_ack_q <= l_ack_d;
      c_err_q <= c_err_d;
      l_err_q <= l_err_d;
      c_rdata_q <= c_rdata_d;
      l_rdata_q <= l_rdata_d;
    end
  end
  assign c_ack = c_ack_q;
  assign l_ack = l_ack_q;
  assign c_err = c_err_q;
  assign l_err = l_err_q;
  assign c_rdata = c_rdata_q;
  assign l_rdata = l_rdata_q;
  assign c_stall = c_req & ~c_ack_q;
  assign m_memwrite = m_memwrite_q;
  assign m_dword = m_dword_q;
  assign m_dataadr = m_dataadr_q;
  assign m_writedata = m_writedata_q;
  assign owner = owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a small big-endian 16-dword memory model.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic c_req = 1'b0, c_dword = 1'b0, l_req = 1'b0, l_dword = 1'b0, l_lock = 1'b0;
  logic [1:0] c_memwrite = 2'd0, l_memwrite = 2'd0;
  logic [63:0] c_adr = '0, c_wdata = '0, l_adr = '0, l_wdata = '0;
  logic c_ack, c_err, c_stall, l_ack, l_err, m_dword, owner;
  logic [63:0] c_rdata, l_rdata, m_dataadr, m_writedata, m_readdata;
  logic [1:0] m_memwrite;
  logic [63:0] mem [16];
  logic mem_init = 1'b0;
  int passed = 0, total = 0, la = 0, ca = 0;

  mem_arbiter #(.N(64)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_memwrite(c_memwrite), .c_dword(c_dword), .c_adr(c_adr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata), .c_err(c_err), .c_stall(c_stall),
    .l_req(l_req), .l_memwrite(l_memwrite), .l_dword(l_dword), .l_adr(l_adr), .l_wdata(l_wdata),
    .l_ack(l_ack), .l_rdata(l_rdata), .l_err(l_err), .l_lock(l_lock),
    .m_memwrite(m_memwrite), .m_dword(m_dword), .m_dataadr(m_dataadr),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .owner(owner)
  );

  always #5 clk = ~clk;

  // byte 0 of a dword sits in bits [63:56]
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= {8{i[7:0]}};
      mem_init <= 1'b1;
    end else if (m_memwrite == 2'd3) mem[m_dataadr[6:3]] <= m_writedata;
    else if (m_memwrite == 2'd1 && m_dataadr[2]) mem[m_dataadr[6:3]][31:0] <= m_writedata[31:0];
    else if (m_memwrite == 2'd1) mem[m_dataadr[6:3]][63:32] <= m_writedata[31:0];
    else if (m_memwrite == 2'd2) mem[m_dataadr[6:3]][(7 - int'(m_dataadr[2:0])) * 8 +: 8] <= m_writedata[7:0];
  end

  assign m_readdata = m_dword ? mem[m_dataadr[6:3]]
                    : {32'd0, m_dataadr[2] ? mem[m_dataadr[6:3]][31:0] : mem[m_dataadr[6:3]][63:32]};

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    tick(3);
    chk("rst_owner", 64'(owner), 64'd1);
    chk("rst_m_memwrite", 64'(m_memwrite), 64'd0);
    chk("rst_m_dword", 64'(m_dword), 64'd0);
    chk("rst_m_dataadr", m_dataadr, 64'd0);
    chk("rst_m_writedata", m_writedata, 64'd0);
    chk("rst_acks", {62'd0, c_ack, l_ack}, 64'd0);
    chk("rst_errs", {62'd0, c_err, l_err}, 64'd0);
    chk("rst_c_rdata", c_rdata, 64'd0);
    chk("rst_l_rdata", l_rdata, 64'd0);
    reset = 1'b1;
    tick();
    // CPU dword write then read-back
    c_req = 1'b1; c_memwrite = 2'd3; c_adr = 64'h10; c_wdata = 64'h1122334455667788;
    tick();
    chk("w_busy_memwrite", 64'(m_memwrite), 64'd3);
    chk("w_busy_ack", 64'(c_ack), 64'd0);
    chk("w_busy_stall", 64'(c_stall), 64'd1);
    chk("w_busy_adr", m_dataadr, 64'h10);
    tick();
    chk("w_done_memwrite", 64'(m_memwrite), 64'd0);
    chk("w_done_ack", 64'(c_ack), 64'd1);
    chk("w_done_err", 64'(c_err), 64'd0);
    chk("w_done_stall", 64'(c_stall), 64'd0);
    chk("w_owner", 64'(owner), 64'd0);
    chk("w_mem", mem[2], 64'h1122334455667788);
    c_req = 1'b0;
    tick();
    chk("w_ack_drop", 64'(c_ack), 64'd0);
    c_req = 1'b1; c_memwrite = 2'd0; c_dword = 1'b1;
    tick(2);
    chk("r_ack", 64'(c_ack), 64'd1);
    chk("r_rdata", c_rdata, 64'h1122334455667788);
    c_req = 1'b0;
    tick();
    // simultaneous reads after reset: C, L, C
    reset = 1'b0;
    tick();
    chk("rst2_owner", 64'(owner), 64'd1);
    reset = 1'b1;
    c_req = 1'b1; l_req = 1'b1; l_memwrite = 2'd0; l_dword = 1'b1; l_adr = 64'h10;
    tick();
    chk("tie_owner_c", 64'(owner), 64'd0);
    chk("tie_read_memwrite", 64'(m_memwrite), 64'd0);
    tick();
    chk("tie_c_ack1", {62'd0, c_ack, l_ack}, 64'd2);
    tick(3);
    chk("tie_l_ack", {62'd0, c_ack, l_ack}, 64'd1);
    chk("tie_l_rdata", l_rdata, 64'h1122334455667788);
    tick(3);
    chk("tie_c_ack2", {62'd0, c_ack, l_ack}, 64'd2);
    // loader lock starves C
    l_lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      la += int'(l_ack);
      ca += int'(c_ack);
    end
    chk("lock_l_acks", 64'(la), 64'd3);
    chk("lock_c_acks", 64'(ca), 64'd0);
    l_lock = 1'b0;
    tick();
    chk("unlock_owner_c", 64'(owner), 64'd0);
    tick();
    chk("unlock_c_ack", {62'd0, c_ack, l_ack}, 64'd2);
    c_req = 1'b0; l_req = 1'b0;
    tick();
    // misaligned dword write
    c_req = 1'b1; c_memwrite = 2'd3; c_adr = 64'h14; c_wdata = '1;
    tick();
    chk("mis_busy_memwrite", 64'(m_memwrite), 64'd0);
    tick();
    chk("mis_done_memwrite", 64'(m_memwrite), 64'd0);
    chk("mis_ack_err", {62'd0, c_ack, c_err}, 64'd3);
    chk("mis_mem", mem[2], 64'h1122334455667788);
    c_req = 1'b0;
    tick();
    // loader byte write
    l_req = 1'b1; l_memwrite = 2'd2; l_adr = 64'h0B; l_wdata = 64'hAB;
    tick();
    chk("byte_memwrite", 64'(m_memwrite), 64'd2);
    tick();
    chk("byte_ack_err", {62'd0, l_ack, l_err}, 64'd2);
    chk("byte_mem", mem[1], 64'h010101AB01010101);
    l_req = 1'b0;
    tick();
    // reset asserted while a write is in BUSY
    c_req = 1'b1; c_memwrite = 2'd3; c_adr = 64'h18; c_wdata = 64'hDEADBEEFCAFEF00D;
    tick();
    chk("rb_busy_memwrite", 64'(m_memwrite), 64'd3);
    #2 reset = 1'b0;
    #1 chk("rb_async_clear", 64'(m_memwrite), 64'd0);
    tick();
    chk("rb_mem", mem[3], 64'h0303030303030303);
    chk("rb_no_ack", 64'(c_ack), 64'd0);
    c_req = 1'b0;
    reset = 1'b1;
    tick(3);
    chk("rb_still_no_ack", 64'(c_ack), 64'd0);
    chk("rb_mem_after", mem[3], 64'h0303030303030303);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
